net_rx_sf_fifo: RTL and testbench

NET_RX_SF_FIFO -- requirements
Module: net_rx_sf_fifo

---
 rtl/net_rx_sf_fifo.sv | 149 ++++++++++++++
 tb/tb_net_rx_sf_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_rx_sf_fifo.sv
// Store-and-forward receive FIFO: packets become visible on egress only once fully written;
// overflow discards the whole packet. Define NET_RX_SF_FIFO_STATS_EN to add packet counters.
module net_rx_sf_fifo #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH/8,
   parameter int unsigned DEPTH_LOG2 = 6
) (
   input  logic                  clk_250mhz,
   input  logic                  clk_250mhz_rst,
   input  logic [DATA_WIDTH-1:0] s_axis_net_rx_data,
   input  logic [KEEP_WIDTH-1:0] s_axis_net_rx_keep,
   input  logic                  s_axis_net_rx_last,
   input  logic                  s_axis_net_rx_valid,
   output logic                  s_axis_net_rx_ready,
   output logic [DATA_WIDTH-1:0] m_axis_net_rx_data,
   output logic [KEEP_WIDTH-1:0] m_axis_net_rx_keep,
   output logic                  m_axis_net_rx_last,
   output logic                  m_axis_net_rx_valid,
   input  logic                  m_axis_net_rx_ready,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  drop_pulse
`ifdef NET_RX_SF_FIFO_STATS_EN
   ,
   output logic [31:0]           fwd_pkt_cnt,
   output logic [31:0]           drop_pkt_cnt
`endif
);

   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned ENT_W = DATA_WIDTH + KEEP_WIDTH + 1;

   typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] level_q, level_d;
   logic             drop_pulse_q, drop_pulse_d;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [ENT_W-1:0] rd_ent_c;
   logic [PTR_W-1:0] used_c;
   logic             in_beat_c, full_c, pop_c, wr_en_c, m_valid_c;

   // Overflow is resolved by dropping, so ingress is only held off during reset.
   assign s_axis_net_rx_ready = ~clk_250mhz_rst;
   assign in_beat_c           = s_axis_net_rx_valid & s_axis_net_rx_ready;

   assign rd_ent_c  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
   assign m_valid_c = (rd_ptr_q != commit_ptr_q);
   assign pop_c     = m_valid_c & m_axis_net_rx_ready;

   // Full uses this cycle's registered rd_ptr; a concurrent pop frees space only next cycle.
   assign used_c = wr_ptr_q - rd_ptr_q;
   assign full_c = (used_c == PTR_W'(DEPTH));

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      drop_pulse_d = 1'b0;
      wr_en_c      = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            if (in_beat_c) begin
               if (!full_c) begin
                  wr_en_c  = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  if (s_axis_net_rx_last) commit_ptr_d = wr_ptr_q + PTR_W'(1);
               end else begin
                  // Rewind the partial packet; finish discarding it in DROP unless this was its end.
                  wr_ptr_d = commit_ptr_q;
                  if (s_axis_net_rx_last) drop_pulse_d = 1'b1;
                  else                    state_d      = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (in_beat_c && s_axis_net_rx_last) begin
               drop_pulse_d = 1'b1;
               state_d      = ST_ACCEPT;
            end
         end
         default: state_d = ST_ACCEPT;
      endcase
      level_d = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge clk_250mhz) begin
      if (clk_250mhz_rst) begin
         state_q      <= ST_ACCEPT;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         drop_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   // Packet storage: no reset, content is only meaningful behind commit_ptr.
   always_ff @(posedge clk_250mhz) begin
      if (wr_en_c)
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_net_rx_last, s_axis_net_rx_keep, s_axis_net_rx_data};
   end

   assign m_axis_net_rx_data  = rd_ent_c[DATA_WIDTH-1:0];
   assign m_axis_net_rx_keep  = rd_ent_c[DATA_WIDTH +: KEEP_WIDTH];
   assign m_axis_net_rx_last  = rd_ent_c[ENT_W-1];
   assign m_axis_net_rx_valid = m_valid_c;
   assign fifo_level          = level_q;
   assign drop_pulse          = drop_pulse_q;

`ifdef NET_RX_SF_FIFO_STATS_EN
   logic [31:0] fwd_cnt_q, fwd_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   // Forward count wraps; drop count saturates.
   always_comb begin
      fwd_cnt_d  = fwd_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (pop_c && rd_ent_c[ENT_W-1]) fwd_cnt_d = fwd_cnt_q + 32'd1;
      if (drop_pulse_d && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_250mhz) begin
      if (clk_250mhz_rst) begin
         fwd_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         fwd_cnt_q  <= fwd_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign fwd_pkt_cnt  = fwd_cnt_q;
   assign drop_pkt_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_net_rx_sf_fifo.sv
// Directed bench for net_rx_sf_fifo: single packet, overflow, oversize, mid-packet reset, random traffic.
module tb_net_rx_sf_fifo;
   localparam int unsigned DW    = 512;
   localparam int unsigned KW    = DW/8;
   localparam int unsigned DL    = 6;
   localparam int unsigned DEPTH = 1 << DL;
   localparam int unsigned NPKT  = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_data;
   logic [KW-1:0] s_keep;
   logic          s_last, s_valid, s_ready;
   logic [DW-1:0] m_data;
   logic [KW-1:0] m_keep;
   logic          m_last, m_valid, m_ready;
   logic [DL:0]   fifo_level;
   logic          drop_pulse;
`ifdef NET_RX_SF_FIFO_STATS_EN
   logic [31:0]   fwd_pkt_cnt, drop_pkt_cnt;
`endif

   net_rx_sf_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(DL)) dut (
      .clk_250mhz          (clk),
      .clk_250mhz_rst      (rst),
      .s_axis_net_rx_data  (s_data),
      .s_axis_net_rx_keep  (s_keep),
      .s_axis_net_rx_last  (s_last),
      .s_axis_net_rx_valid (s_valid),
      .s_axis_net_rx_ready (s_ready),
      .m_axis_net_rx_data  (m_data),
      .m_axis_net_rx_keep  (m_keep),
      .m_axis_net_rx_last  (m_last),
      .m_axis_net_rx_valid (m_valid),
      .m_axis_net_rx_ready (m_ready),
      .fifo_level          (fifo_level),
      .drop_pulse          (drop_pulse)
`ifdef NET_RX_SF_FIFO_STATS_EN
      ,
      .fwd_pkt_cnt         (fwd_pkt_cnt),
      .drop_pkt_cnt        (drop_pkt_cnt)
`endif
   );

   always #2 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit rand_ready = 1'b0;

   logic [DW-1:0] oq_data [$];
   logic [KW-1:0] oq_keep [$];
   logic          oq_last [$];
   int            drop_seen = 0;
   int            valid_cycles = 0;

   // Egress / drop monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && m_ready) begin
            oq_data.push_back(m_data);
            oq_keep.push_back(m_keep);
            oq_last.push_back(m_last);
         end
         if (drop_pulse) drop_seen++;
         if (m_valid) valid_cycles++;
      end
   end

   function automatic logic [DW-1:0] mk_data(input int id, input int idx, input int len);
      logic [DW-1:0] d;
      d = '0;
      d[31:0]  = 32'(id);
      d[47:32] = 16'(idx);
      d[63:48] = 16'(len);
      for (int w = 2; w < int'(DW/32); w++) d[w*32 +: 32] = 32'(id*131 + idx*7 + w) ^ 32'h5A5A_A5A5;
      return d;
   endfunction

   function automatic logic [KW-1:0] mk_keep(input int id, input int idx, input int len);
      logic [KW-1:0] k;
      k = '1;
      if (idx == len-1) k = k >> (id % int'(KW));
      return k;
   endfunction

   task automatic drive_beat(input int id, input int idx, input int len);
      @(posedge clk); #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      s_valid = 1'b1;
      s_data  = mk_data(id, idx, len);
      s_keep  = mk_keep(id, idx, len);
      s_last  = (idx == len-1);
   endtask

   task automatic drive_idle();
      @(posedge clk); #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_pkt(input int id, input int len);
      for (int i = 0; i < len; i++) drive_beat(id, i, len);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk); #1;
      m_ready = v;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      do begin
         drive_idle();
         @(negedge clk);
         n++;
      end while (m_valid && n < budget);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain_timeout: m_valid=%b after %0d cycles, need 0", m_valid, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b need 0", s_ready); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b need 0", m_valid); end
      n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL rst_level: got %0d need 0", fifo_level); end
      n_cmp++; if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b need 0", drop_pulse); end
`ifdef NET_RX_SF_FIFO_STATS_EN
      n_cmp++; if ({fwd_pkt_cnt, drop_pkt_cnt} !== 64'd0) begin n_err++;
         $display("FAIL rst_cnt: got %0d/%0d need 0/0", fwd_pkt_cnt, drop_pkt_cnt); end
`endif
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL run_ready: got %b need 1", s_ready); end
   endtask

   task automatic test_single_packet();
      int base;
      base = oq_data.size();
      set_ready(1'b1);
      drive_beat(1, 0, 3);
      @(negedge clk);
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL sf_early_valid: got %b need 0", m_valid); end
      drive_beat(1, 1, 3);
      drive_beat(1, 2, 3);
      @(negedge clk);
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL sf_last_cycle_valid: got %b need 0", m_valid); end
      n_cmp++; if (fifo_level !== 7'd2) begin n_err++; $display("FAIL sf_level2: got %0d need 2", fifo_level); end
      drive_idle();
      @(negedge clk);
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL sf_latency: got %b need 1", m_valid); end
      n_cmp++; if (m_data !== mk_data(1, 0, 3)) begin n_err++; $display("FAIL sf_first_data: got %h need %h", m_data[63:0], mk_data(1,0,3)); end
      n_cmp++; if (fifo_level !== 7'd3) begin n_err++; $display("FAIL sf_level3: got %0d need 3", fifo_level); end
      repeat (4) drive_idle();
      @(negedge clk);
      n_cmp++; if (oq_data.size() - base !== 3) begin n_err++; $display("FAIL sf_count: got %0d need 3", oq_data.size() - base); end
      for (int i = 0; i < 3 && base + i < oq_data.size(); i++) begin
         n_cmp++;
         if (oq_data[base+i] !== mk_data(1, i, 3) || oq_keep[base+i] !== mk_keep(1, i, 3) || oq_last[base+i] !== (i == 2)) begin
            n_err++; $display("FAIL sf_flit%0d: got id/idx %h last %b, need idx %0d last %b", i, oq_data[base+i][63:0], oq_last[base+i], i, (i == 2));
         end
      end
      n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL sf_level_end: got %0d need 0", fifo_level); end
   endtask

   task automatic test_overflow();
      int base, d0, bad;
      d0 = drop_seen;
      set_ready(1'b0);
      for (int p = 0; p < 8; p++) send_pkt(10 + p, 8);
      drive_idle();
      @(negedge clk);
      n_cmp++; if (fifo_level !== 7'd64) begin n_err++; $display("FAIL ovf_level_full: got %0d need 64", fifo_level); end
      send_pkt(18, 8);
      drive_idle();
      @(negedge clk);
      n_cmp++; if (drop_pulse !== 1'b1) begin n_err++; $display("FAIL ovf_drop_pulse: got %b need 1", drop_pulse); end
      n_cmp++; if (fifo_level !== 7'd64) begin n_err++; $display("FAIL ovf_level_after: got %0d need 64", fifo_level); end
      repeat (3) drive_idle();
      @(negedge clk);
      n_cmp++; if (drop_seen - d0 !== 1) begin n_err++; $display("FAIL ovf_drop_count: got %0d need 1", drop_seen - d0); end
`ifdef NET_RX_SF_FIFO_STATS_EN
      n_cmp++; if (drop_pkt_cnt !== 32'd1) begin n_err++; $display("FAIL ovf_drop_pkt_cnt: got %0d need 1", drop_pkt_cnt); end
`endif
      base = oq_data.size();
      set_ready(1'b1);
      drain(200);
      n_cmp++; if (oq_data.size() - base !== 64) begin n_err++; $display("FAIL ovf_out_count: got %0d need 64", oq_data.size() - base); end
      bad = 0;
      for (int i = 0; i < 64 && base + i < oq_data.size(); i++)
         if (oq_data[base+i] !== mk_data(10 + i/8, i%8, 8) || oq_last[base+i] !== (i%8 == 7)) bad++;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ovf_out_order: %0d bad flits, need 0", bad); end
   endtask

   task automatic test_oversize();
      int v0, d0;
      set_ready(1'b1);
      v0 = valid_cycles; d0 = drop_seen;
      send_pkt(30, DEPTH + 1);
      drive_idle();
      @(negedge clk);
      n_cmp++; if (drop_pulse !== 1'b1) begin n_err++; $display("FAIL big_drop_pulse: got %b need 1", drop_pulse); end
      n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL big_level: got %0d need 0", fifo_level); end
      repeat (3) drive_idle();
      @(negedge clk);
      n_cmp++; if (valid_cycles - v0 !== 0) begin n_err++; $display("FAIL big_valid_seen: got %0d cycles need 0", valid_cycles - v0); end
      n_cmp++; if (drop_seen - d0 !== 1) begin n_err++; $display("FAIL big_drop_count: got %0d need 1", drop_seen - d0); end
   endtask

   task automatic test_reset_mid();
      int base;
      set_ready(1'b1);
      drive_beat(40, 0, 4);
      drive_beat(40, 1, 4);
      drive_idle();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b need 0", m_valid); end
      n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL rmid_level: got %0d need 0", fifo_level); end
      base = oq_data.size();
      send_pkt(41, 1);
      repeat (5) drive_idle();
      @(negedge clk);
      n_cmp++; if (oq_data.size() - base !== 1) begin n_err++; $display("FAIL rmid_count: got %0d need 1", oq_data.size() - base); end
      if (oq_data.size() > base) begin
         n_cmp++;
         if (oq_data[base] !== mk_data(41, 0, 1) || oq_last[base] !== 1'b1 || oq_keep[base] !== mk_keep(41, 0, 1)) begin
            n_err++; $display("FAIL rmid_flit: got %h last %b need id 41 last 1", oq_data[base][63:0], oq_last[base]);
         end
      end
   endtask

   task automatic test_random();
      int base, d0, i, exp_min, fwd, bad, id, len, flits;
      int len_tab [NPKT];
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      base = oq_data.size(); d0 = drop_seen;
      rand_ready = 1'b1;
      for (int p = 0; p < int'(NPKT); p++) begin
         len_tab[p] = $urandom_range(1, 16);
         send_pkt(100 + p, len_tab[p]);
         if ($urandom_range(0, 3) == 0) drive_idle();
      end
      drive_idle();
      rand_ready = 1'b0;
      set_ready(1'b1);
      drain(300);
      i = base; exp_min = 100; fwd = 0; bad = 0; flits = oq_data.size() - base;
      while (i < oq_data.size() && bad == 0) begin
         id = int'(oq_data[i][31:0]);
         n_cmp++;
         if (id < exp_min || id >= 100 + int'(NPKT)) begin
            n_err++; bad = 1; $display("FAIL rnd_pkt_id: got %0d need >= %0d", id, exp_min);
         end else begin
            len = len_tab[id - 100];
            for (int j = 0; j < len; j++)
               if (i + j >= oq_data.size() || oq_data[i+j] !== mk_data(id, j, len) ||
                   oq_keep[i+j] !== mk_keep(id, j, len) || oq_last[i+j] !== (j == len-1)) bad = 1;
            if (bad != 0) begin
               n_err++; $display("FAIL rnd_pkt_body: packet %0d len %0d corrupted", id, len);
            end
            i += len; exp_min = id + 1; fwd++;
         end
      end
      n_cmp++; if (fwd + (drop_seen - d0) !== int'(NPKT)) begin n_err++;
         $display("FAIL rnd_total: fwd %0d + drop %0d, need %0d", fwd, drop_seen - d0, NPKT); end
      n_cmp++; if ((flits > 2*int'(DEPTH)) !== 1'b1) begin n_err++; $display("FAIL rnd_wrap: only %0d flits out", flits); end
      n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL rnd_level_end: got %0d need 0", fifo_level); end
`ifdef NET_RX_SF_FIFO_STATS_EN
      n_cmp++; if (fwd_pkt_cnt + drop_pkt_cnt !== 32'(NPKT) || fwd_pkt_cnt !== 32'(fwd)) begin n_err++;
         $display("FAIL rnd_stats: fwd_pkt_cnt %0d drop_pkt_cnt %0d, need fwd %0d sum %0d", fwd_pkt_cnt, drop_pkt_cnt, fwd, NPKT); end
`endif
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_packet();
      test_overflow();
      test_oversize();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
